// File: rtl/loader_pkg.sv
// Shared types, constants and checksum helpers for the instruction-memory boot loader.
package loader_pkg;

    localparam int LEN_W = 16;
    localparam int LANES = 4;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // A frame may fill the memory exactly but never exceed it, so the address can never wrap.
    function automatic logic len_oversize(input logic [LEN_W-1:0] len, input int addr_w);
        logic [31:0] cap;
        cap = 32'd1 << addr_w;
        return {{(32-LEN_W){1'b0}}, len} > cap;
    endfunction

    function automatic logic [LEN_W+1:0] payload_bytes(input logic [LEN_W-1:0] len);
        return {len, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_checker.sv
// Invariants of the loader's output interface, kept apart from the datapath.
module imem_loader_checker (
    input logic clk,
    input logic rst,
    input logic in_ready,
    input logic busy,
    input logic imem_wr_en,
    input logic core_rst_n,
    input logic done,
    input logic error
);

    a_ready_busy: assert property (@(posedge clk) disable iff (rst) in_ready == busy);

    a_done_xor_error: assert property (@(posedge clk) disable iff (rst) !(done && error));

    a_core_released_only_when_done: assert property (@(posedge clk) disable iff (rst)
        core_rst_n == done);

    // Each word takes four bytes, so write strobes can never be back to back.
    a_wr_single_cycle: assert property (@(posedge clk) disable iff (rst)
        imem_wr_en |=> !imem_wr_en);

endmodule

// File: rtl/word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word and emits a one-cycle
// registered word_valid pulse together with the completed word.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [31:0] shift_r;
    logic [1:0]  lane_r;
    logic        word_valid_r;
    logic [31:0] word_data_r;
    logic [31:0] shift_next_s;

    // New bytes enter at the top, so after four shifts lane k sits in bits [8k+7:8k].
    assign shift_next_s = {byte_data, shift_r[31:8]};

    // Lane counter, shift register and registered word strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= 32'd0;
            lane_r       <= 2'd0;
            word_valid_r <= 1'b0;
            word_data_r  <= 32'd0;
        end else if (clr) begin
            shift_r      <= 32'd0;
            lane_r       <= 2'd0;
            word_valid_r <= 1'b0;
        end else if (byte_valid) begin
            shift_r <= shift_next_s;
            if (lane_r == LAST_LANE) begin
                lane_r       <= 2'd0;
                word_valid_r <= 1'b1;
                word_data_r  <= shift_next_s;
            end else begin
                lane_r       <= lane_r + 2'd1;
                word_valid_r <= 1'b0;
            end
        end else begin
            word_valid_r <= 1'b0;
        end
    end

    assign word_valid = word_valid_r;
    assign word_data  = word_data_r;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream as LEN_LO, LEN_HI, payload, CSUM, writes the payload
// words into instruction memory and releases the core only after the checksum matches.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W+1:0]   CNT_ONE  = (LEN_W + 2)'(1);

    state_t              state_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                core_rst_n_r;
    logic [7:0]          len_lo_r;
    logic [7:0]          xor_r;
    logic [LEN_W+1:0]    cnt_r;
    logic [ADDR_W-1:0]   addr_r;

    logic                accept_s;
    logic                launch_s;
    logic                data_byte_s;
    logic                word_valid_s;
    logic [31:0]         word_data_s;
    logic [LEN_W-1:0]    len_s;

    assign accept_s    = in_valid && in_ready_r;
    assign launch_s    = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    assign data_byte_s = accept_s && (state_r == DATA);
    assign len_s       = {in_data, len_lo_r};

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (launch_s),
        .byte_valid (data_byte_s),
        .byte_data  (in_data),
        .word_valid (word_valid_s),
        .word_data  (word_data_s)
    );

    // Frame FSM with its registered handshake/status outputs, length counter, XOR and address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            core_rst_n_r <= 1'b0;
            len_lo_r     <= 8'd0;
            xor_r        <= 8'd0;
            cnt_r        <= {(LEN_W + 2){1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
        end else begin
            if (word_valid_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (launch_s) begin
                        state_r      <= LEN_LO;
                        in_ready_r   <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                        core_rst_n_r <= 1'b0;
                        len_lo_r     <= 8'd0;
                        xor_r        <= 8'd0;
                        cnt_r        <= {(LEN_W + 2){1'b0}};
                        addr_r       <= {ADDR_W{1'b0}};
                    end
                end
                LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r <= in_data;
                        xor_r    <= csum_update(xor_r, in_data);
                        state_r  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        xor_r <= csum_update(xor_r, in_data);
                        if (len_oversize(len_s, ADDR_W)) begin
                            state_r    <= ERR;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            error_r    <= 1'b1;
                        end else if (len_s == {LEN_W{1'b0}}) begin
                            state_r <= CSUM;
                        end else begin
                            state_r <= DATA;
                            cnt_r   <= payload_bytes(len_s);
                        end
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        xor_r <= csum_update(xor_r, in_data);
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        if (in_data == xor_r) begin
                            state_r      <= DONE;
                            done_r       <= 1'b1;
                            core_rst_n_r <= 1'b1;
                        end else begin
                            state_r <= ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    in_ready_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    error_r      <= 1'b0;
                    core_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign core_rst_n   = core_rst_n_r;
    assign imem_wr_en   = word_valid_s;
    assign imem_wr_addr = addr_r;
    assign imem_wr_data = word_data_s;

    imem_loader_checker u_chk (
        .clk        (clk),
        .rst        (rst),
        .in_ready   (in_ready_r),
        .busy       (busy_r),
        .imem_wr_en (word_valid_s),
        .core_rst_n (core_rst_n_r),
        .done       (done_r),
        .error      (error_r)
    );

endmodule
